// File: rtl/twitch_pkg.sv
// twitch_pkg: shared constants for the twitchcore memory responder.
//   TW_MMIO_TX / TW_MMIO_HOST : default word addresses of the MMIO window
//   ST_*                      : bit positions inside the TX status word
//   tx_status()               : packs FIFO state into the status word
package twitch_pkg;

    localparam int unsigned TW_MMIO_TX   = 32'h0000_0FF0;
    localparam int unsigned TW_MMIO_HOST = 32'h0000_0FF1;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_CNT   = 8;

    function automatic logic [31:0] tx_status(
        input logic [3:0] cnt,
        input logic       ovf,
        input logic       full,
        input logic       empty
    );
        logic [31:0] s;
        s               = '0;
        s[ST_CNT +: 4]  = cnt;
        s[ST_OVF]       = ovf;
        s[ST_FULL]      = full;
        s[ST_EMPTY]     = empty;
        return s;
    endfunction

endpackage

// File: rtl/twitch_txfifo.sv
// twitch_txfifo: console TX byte FIFO, no fall-through.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write strobe and byte; ignored when full unless popping too
//   full       : count == DEPTH
//   pop        : read strobe; ignored when empty
//   dout       : head entry, forced to 0 while empty
//   empty      : count == 0
//   count      : occupancy, $clog2(DEPTH)+1 bits
module twitch_txfifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 din,
    output logic                       full,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import twitch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign count  = r_count;
    // Zero while empty so the head output is clean after reset.
    assign dout   = empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/twitchmem.sv
// twitchmem: responder end of the twitchcore memory interface.
//   clk, resetn           : clock, synchronous reset (active HIGH despite the name)
//   i_addr -> i_data      : instruction fetch, 1-cycle registered read
//   d_addr -> d_data      : data load, 1-cycle registered read (RAM or MMIO)
//   dw_data/dw_en/dw_mask : data store, byte-lane masked
//   tx_valid/tx_data/tx_ready : console byte stream out of the TX FIFO
//   tohost/tohost_valid   : last MMIO_HOST write and sticky written flag
// One RAM backs both read ports and the single write port; all reads are
// read-first so a same-cycle store is only visible on the following read.
module twitchmem
    import twitch_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 12,
    parameter int unsigned          MEM_WORDS  = 4096,
    parameter string                INIT_FILE  = "",
    parameter logic [ADDR_W-1:0]    MMIO_TX    = ADDR_W'(TW_MMIO_TX),
    parameter logic [ADDR_W-1:0]    MMIO_HOST  = ADDR_W'(TW_MMIO_HOST),
    parameter int unsigned          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_data,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [31:0]       d_data,
    input  logic [31:0]       dw_data,
    input  logic              dw_en,
    input  logic [3:0]        dw_mask,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [31:0]       tohost,
    output logic              tohost_valid
);

    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_mem [MEM_WORDS];
    logic [31:0]       r_tohost;
    logic              r_tohost_valid;
    logic              r_ovf;

    logic              w_d_is_tx;
    logic              w_d_is_host;
    logic              w_d_in_ram;
    logic              w_i_in_ram;
    logic [MEM_AW-1:0] w_d_idx;
    logic [MEM_AW-1:0] w_i_idx;
    logic              w_wr_ok;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_dout;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_status;
    logic [31:0]       w_d_rdata;

    assign w_d_is_tx   = (d_addr == MMIO_TX);
    assign w_d_is_host = (d_addr == MMIO_HOST);
    // MMIO decode wins over RAM even when the window lies inside MEM_WORDS.
    assign w_d_in_ram  = (32'(d_addr) < MEM_WORDS) && !w_d_is_tx && !w_d_is_host;
    assign w_i_in_ram  = (32'(i_addr) < MEM_WORDS) && (i_addr != MMIO_TX) && (i_addr != MMIO_HOST);
    assign w_d_idx     = d_addr[MEM_AW-1:0];
    assign w_i_idx     = i_addr[MEM_AW-1:0];

    // Stores presented during reset are dropped.
    assign w_wr_ok = dw_en & ~resetn;
    assign w_pop   = ~w_empty & tx_ready;
    // A push into a full FIFO is legal only if the head leaves this cycle.
    assign w_push  = w_wr_ok & w_d_is_tx & (~w_full | w_pop);

    twitch_txfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_txfifo (
        .clk   (clk),
        .rst   (resetn),
        .push  (w_push),
        .din   (dw_data[7:0]),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .count (w_count)
    );

    assign tx_valid     = ~w_empty;
    assign tx_data      = w_dout;
    assign tohost       = r_tohost;
    assign tohost_valid = r_tohost_valid;

    // Status reflects registered state, i.e. before this cycle's push/pop.
    assign w_status = tx_status(4'(w_count), r_ovf, w_full, w_empty);

    always_comb begin
        w_d_rdata = '0;
        if (w_d_is_tx) begin
            w_d_rdata = w_status;
        end else if (w_d_is_host) begin
            w_d_rdata = r_tohost;
        end else if (w_d_in_ram) begin
            w_d_rdata = r_mem[w_d_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && w_d_in_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (dw_mask[k]) begin
                    r_mem[w_d_idx][8*k +: 8] <= dw_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            i_data         <= '0;
            d_data         <= '0;
            r_tohost       <= '0;
            r_tohost_valid <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            i_data <= w_i_in_ram ? r_mem[w_i_idx] : 32'h0;
            d_data <= w_d_rdata;
            if (w_wr_ok && w_d_is_host) begin
                r_tohost       <= dw_data;
                r_tohost_valid <= 1'b1;
            end
            if (w_wr_ok && w_d_is_tx && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_twitchmem.sv
module tb_twitchmem;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] i_addr;
    logic [31:0] i_data;
    logic [11:0] d_addr;
    logic [31:0] d_data;
    logic [31:0] dw_data;
    logic        dw_en;
    logic [3:0]  dw_mask;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] tohost;
    logic        tohost_valid;

    always #5 clk = ~clk;

    twitchmem dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .d_addr       (d_addr),
        .d_data       (d_data),
        .dw_data      (dw_data),
        .dw_en        (dw_en),
        .dw_mask      (dw_mask),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .tohost       (tohost),
        .tohost_valid (tohost_valid)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        q_d[$];
    exp_t        q_i[$];
    logic [7:0]  q_tx[$];
    exp_t        e_d;
    exp_t        e_i;
    logic [7:0]  e_tx;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Scoreboard monitor: compares registered read data on its due cycle and
    // every byte the sink accepts against the expected byte stream.
    always @(negedge clk) begin
        if (q_d.size() > 0 && q_d[0].due == cyc) begin
            e_d = q_d.pop_front();
            check(e_d.name, d_data, e_d.val);
        end
        if (q_i.size() > 0 && q_i[0].due == cyc) begin
            e_i = q_i.pop_front();
            check(e_i.name, i_data, e_i.val);
        end
        if (!resetn && tx_valid && tx_ready) begin
            if (q_tx.size() == 0) begin
                n_total++;
                $display("FAIL tx_unexpected: got %h want no byte", tx_data);
            end else begin
                e_tx = q_tx.pop_front();
                check("tx_byte", {24'h0, tx_data}, {24'h0, e_tx});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dw_en   = 1'b0;
        dw_mask = 4'hF;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v, input logic [3:0] m);
        d_addr  = a;
        dw_data = v;
        dw_mask = m;
        dw_en   = 1'b1;
    endtask

    task automatic exp_d(input logic [31:0] v, input string name);
        q_d.push_back('{cyc + 1, v, name});
    endtask

    task automatic exp_i(input logic [31:0] v, input string name);
        q_i.push_back('{cyc + 1, v, name});
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] v, input string name);
        idle();
        d_addr = a;
        exp_d(v, name);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_i_data"},       i_data, 32'h0);
        check({tag, "_d_data"},       d_data, 32'h0);
        check({tag, "_tx_valid"},     {31'h0, tx_valid}, 32'h0);
        check({tag, "_tx_data"},      {24'h0, tx_data}, 32'h0);
        check({tag, "_tohost"},       tohost, 32'h0);
        check({tag, "_tohost_valid"}, {31'h0, tohost_valid}, 32'h0);
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && tx_valid; k++) tick();
        if (tx_valid) begin
            n_total++;
            $display("FAIL %s_drain_timeout: got tx_valid=1 want 0", tag);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        resetn   = 1'b1;
        i_addr   = 12'h0;
        d_addr   = 12'h0;
        dw_data  = 32'h0;
        tx_ready = 1'b0;
        idle();
        tick();
        tick();
        check_reset_outputs("reset");
        resetn = 1'b0;

        rd(12'hFF0, 32'h0000_0001, "status_after_reset");

        // 1: full-word store then load
        wr(12'h010, 32'hDEADBEEF, 4'hF);
        tick();
        rd(12'h010, 32'hDEADBEEF, "store_load_010");

        // 2: masked store, read-first on the d port
        wr(12'h005, 32'h1122_3344, 4'hF);
        tick();
        wr(12'h005, 32'hAABB_CCDD, 4'b0101);
        exp_d(32'h1122_3344, "d_read_during_write");
        tick();
        rd(12'h005, 32'h11BB_33DD, "masked_store");

        // 6: read-first on the i port, then the new word
        wr(12'h003, 32'h1234_5678, 4'hF);
        tick();
        wr(12'h003, 32'hCAFE_F00D, 4'hF);
        i_addr = 12'h003;
        exp_i(32'h1234_5678, "i_read_during_write");
        tick();
        idle();
        exp_i(32'hCAFE_F00D, "i_fetch_new");
        tick();
        i_addr = 12'hFF0;
        exp_i(32'h0, "i_mmio_zero");
        tick();
        i_addr = 12'h010;
        exp_i(32'hDEADBEEF, "i_fetch_010");
        tick();

        // 3: overflow with the sink stalled
        for (int k = 0; k < 9; k++) begin
            wr(12'hFF0, 32'hFFFF_FF41 + 32'(k), 4'h0);
            if (k < 8) q_tx.push_back(8'h41 + 8'(k));
            tick();
        end
        rd(12'hFF0, 32'h0000_0806, "status_full_ovf");
        check("head_stable", {24'h0, tx_data}, 32'h41);
        drain("ovf");
        rd(12'hFF0, 32'h0000_0005, "status_empty_ovf_sticky");

        // 4: push into a full FIFO while it pops -> accepted, no overflow
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr(12'hFF0, 32'h0000_0061 + 32'(k), 4'hF);
            q_tx.push_back(8'h61 + 8'(k));
            tick();
        end
        wr(12'hFF0, 32'h0000_005A, 4'hF);
        tx_ready = 1'b1;
        q_tx.push_back(8'h5A);
        tick();
        tx_ready = 1'b0;
        rd(12'hFF0, 32'h0000_0802, "status_full_no_ovf");
        check("head_after_pop", {24'h0, tx_data}, 32'h62);
        drain("pushpop");
        rd(12'hFF0, 32'h0000_0001, "status_empty_clean");

        // 5: tohost, then reset mid-stream
        check("tohost_valid_before", {31'h0, tohost_valid}, 32'h0);
        wr(12'hFF1, 32'h0000_0001, 4'hF);
        tick();
        check("tohost", tohost, 32'h1);
        check("tohost_valid", {31'h0, tohost_valid}, 32'h1);
        rd(12'hFF1, 32'h0000_0001, "tohost_readback");
        wr(12'hFF1, 32'h0000_00A5, 4'hF);
        tick();
        check("tohost_overwrite", tohost, 32'hA5);
        for (int k = 0; k < 3; k++) begin
            wr(12'hFF0, 32'h0000_0071 + 32'(k), 4'hF);
            tick();
        end
        idle();
        tick();
        check("tx_valid_before_reset", {31'h0, tx_valid}, 32'h1);
        check("tx_data_before_reset", {24'h0, tx_data}, 32'h71);
        resetn = 1'b1;
        wr(12'h010, 32'h0BAD_F00D, 4'hF);
        tick();
        check_reset_outputs("midreset");
        resetn = 1'b0;
        rd(12'h010, 32'hDEADBEEF, "ram_kept_010");
        rd(12'h005, 32'h11BB_33DD, "ram_kept_005");
        rd(12'hFF0, 32'h0000_0001, "status_after_midreset");

        idle();
        for (int k = 0; k < 20 && (q_d.size() + q_i.size() + q_tx.size()) != 0; k++) tick();
        if ((q_d.size() + q_i.size() + q_tx.size()) != 0) begin
            n_total++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0",
                     q_d.size() + q_i.size() + q_tx.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
